gbcam_reg_bridge: RTL and testbench



---
 rtl/gbcam_reg_bridge_if.sv | 22 ++
 rtl/gbcam_reg_bridge.sv | 172 +++++++++++++++++
 tb/tb_gbcam_reg_bridge.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gbcam_reg_bridge_if.sv
// BRAM write-port handshake between the camera register bridge and
// the BRAM arbiter: request held with address/data until done.
interface gbcam_reg_bridge_if;
   logic       Bram_Req_Write;
   logic [9:0] Bram_Addr;
   logic [7:0] Bram_Data;
   logic       Bram_WriteRegDone;

   modport master (
      output Bram_Req_Write,
      output Bram_Addr,
      output Bram_Data,
      input  Bram_WriteRegDone
   );

   modport slave (
      input  Bram_Req_Write,
      input  Bram_Addr,
      input  Bram_Data,
      output Bram_WriteRegDone
   );
endinterface

// File: rtl/gbcam_reg_bridge.sv
// Game Boy camera register window bridge: direct regs + queued BRAM writes.
// Define GBCAM_REG_READBACK_EN to make regs 1..NUM_REGS-1 readable.
module gbcam_reg_bridge #(
   parameter int         NUM_REGS   = 6,
   parameter logic [4:0] REG_BANK   = 5'h10,
   parameter int         ADDR_BITS  = 7,
   parameter logic [9:0] BRAM_BASE  = 10'h200,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic                    sys_clock,
   input  logic                    sys_resetn,
   input  logic [15:0]             Cart_a,
   input  logic [7:0]              Cart_d,
   input  logic                    Cart_nRD,
   input  logic                    Cart_nWR,
   input  logic                    Cart_nCS,
   input  logic [4:0]              Ram_bank_id,
   input  logic                    Sig_CamCaptureFinish,
   output logic                    Reg_OutputValid,
   output logic [7:0]              Reg_OutputData,
   gbcam_reg_bridge_if.master      bram,
   output logic [8*NUM_REGS-1:0]   Reg_Flat,
   output logic                    Cam_Capture,
   output logic                    Fifo_Overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, state_nx;

   logic nwr_s1, nwr_s2, nwr_s3;
   logic ncs_s1, ncs_s2, ncs_s3;
   logic fin_s1, fin_s2, fin_s3;

   logic [7:0]  regs [NUM_REGS];
   logic [17:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;

   logic                 sel, is_reg;
   logic [ADDR_BITS-1:0] off;
   logic [9:0]           bram_wa;
   logic [7:0]           rd_val;
   logic wr_fall, cs_fall, cs_rise, fin_rise;
   logic push_req, push, pop, full, empty;
   logic unused_ok;

   assign unused_ok = ^{Cart_a[12:ADDR_BITS], 1'b0};

   // Third stage gives a registered edge: pin edge at k acts at k+2
   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         {nwr_s1, nwr_s2, nwr_s3} <= 3'b111;
         {ncs_s1, ncs_s2, ncs_s3} <= 3'b111;
         {fin_s1, fin_s2, fin_s3} <= 3'b000;
      end else begin
         {nwr_s1, nwr_s2, nwr_s3} <= {Cart_nWR, nwr_s1, nwr_s2};
         {ncs_s1, ncs_s2, ncs_s3} <= {Cart_nCS, ncs_s1, ncs_s2};
         {fin_s1, fin_s2, fin_s3} <= {Sig_CamCaptureFinish, fin_s1, fin_s2};
      end
   end

   assign wr_fall  = nwr_s3 & ~nwr_s2;
   assign cs_fall  = ncs_s3 & ~ncs_s2;
   assign cs_rise  = ~ncs_s3 & ncs_s2;
   assign fin_rise = fin_s2 & ~fin_s3;

   assign sel = (Cart_a[15:13] == 3'b101) && !Cart_nCS &&
                (Ram_bank_id == REG_BANK);
   assign off     = Cart_a[ADDR_BITS-1:0];
   assign is_reg  = int'(off) < NUM_REGS;
   assign bram_wa = BRAM_BASE + 10'(off) - 10'(NUM_REGS);

   assign full     = count == (PW+1)'(FIFO_DEPTH);
   assign empty    = count == '0;
   assign push_req = wr_fall && sel && !is_reg;
   assign push     = push_req && !full;

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++)
            if (wr_fall && sel && int'(off) == i) regs[i] <= Cart_d;
         if (fin_rise) regs[0][0] <= 1'b0;
      end
   end

   always_comb begin
      Reg_Flat = '0;
      for (int i = 0; i < NUM_REGS; i++) Reg_Flat[8*i +: 8] = regs[i];
   end

   assign Cam_Capture = regs[0][0];

   always_comb begin
      rd_val = '0;
      if (int'(off) == 0) rd_val = regs[0];
`ifdef GBCAM_REG_READBACK_EN
      for (int i = 1; i < NUM_REGS; i++)
         if (int'(off) == i) rd_val = regs[i];
`endif
   end

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         Reg_OutputValid <= 1'b0;
         Reg_OutputData  <= '0;
      end else if (cs_fall && !Cart_nRD && sel) begin
         Reg_OutputValid <= 1'b1;
         Reg_OutputData  <= rd_val;
      end else if (cs_rise) begin
         Reg_OutputValid <= 1'b0;
         Reg_OutputData  <= '0;
      end
   end

   always_ff @(posedge sys_clock) begin
      if (push) fifo_mem[wr_ptr] <= {bram_wa, Cart_d};
   end

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         Fifo_Overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         if (push_req && full) Fifo_Overflow <= 1'b1;
      end
   end

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) state <= IDLE;
      else             state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      unique case (state)
         IDLE: if (!empty) begin
            pop      = 1'b1;
            state_nx = BUSY;
         end
         BUSY: if (bram.Bram_WriteRegDone) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         bram.Bram_Req_Write <= 1'b0;
         bram.Bram_Addr      <= '0;
         bram.Bram_Data      <= '0;
      end else if (pop) begin
         bram.Bram_Req_Write <= 1'b1;
         bram.Bram_Addr      <= fifo_mem[rd_ptr][17:8];
         bram.Bram_Data      <= fifo_mem[rd_ptr][7:0];
      end else if (state == BUSY && bram.Bram_WriteRegDone) begin
         bram.Bram_Req_Write <= 1'b0;
         bram.Bram_Addr      <= '0;
         bram.Bram_Data      <= '0;
      end
   end

endmodule

// File: tb/tb_gbcam_reg_bridge.sv
// Directed bench for gbcam_reg_bridge: reg writes, capture finish,
// BRAM queue drain/overflow, window decode, readback and reset.
module tb_gbcam_reg_bridge;

   logic        sys_clock = 1'b0;
   logic        sys_resetn;
   logic [15:0] Cart_a;
   logic [7:0]  Cart_d;
   logic        Cart_nRD, Cart_nWR, Cart_nCS;
   logic [4:0]  Ram_bank_id;
   logic        Sig_CamCaptureFinish;
   logic        Reg_OutputValid;
   logic [7:0]  Reg_OutputData;
   logic [47:0] Reg_Flat;
   logic        Cam_Capture;
   logic        Fifo_Overflow;

   int total = 0;
   int bad   = 0;

   gbcam_reg_bridge_if bif ();

   gbcam_reg_bridge dut (
      .sys_clock            (sys_clock),
      .sys_resetn           (sys_resetn),
      .Cart_a               (Cart_a),
      .Cart_d               (Cart_d),
      .Cart_nRD             (Cart_nRD),
      .Cart_nWR             (Cart_nWR),
      .Cart_nCS             (Cart_nCS),
      .Ram_bank_id          (Ram_bank_id),
      .Sig_CamCaptureFinish (Sig_CamCaptureFinish),
      .Reg_OutputValid      (Reg_OutputValid),
      .Reg_OutputData       (Reg_OutputData),
      .bram                 (bif),
      .Reg_Flat             (Reg_Flat),
      .Cam_Capture          (Cam_Capture),
      .Fifo_Overflow        (Fifo_Overflow)
   );

   always #5 sys_clock = ~sys_clock;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d,
                            input logic [4:0] bank);
      @(negedge sys_clock);
      Ram_bank_id = bank;
      Cart_a      = a;
      Cart_d      = d;
      Cart_nCS    = 1'b0;
      repeat (3) @(negedge sys_clock);
      Cart_nWR = 1'b0;
      repeat (4) @(negedge sys_clock);
      Cart_nWR = 1'b1;
      repeat (3) @(negedge sys_clock);
      Cart_nCS = 1'b1;
      repeat (3) @(negedge sys_clock);
   endtask

   task automatic cpu_read(input string tag, input logic [15:0] a,
                           input logic [7:0] exp);
      @(negedge sys_clock);
      Ram_bank_id = 5'h10;
      Cart_a      = a;
      Cart_nRD    = 1'b0;
      @(negedge sys_clock);
      Cart_nCS = 1'b0;
      repeat (2) @(negedge sys_clock);
      chk({tag, "_vld_early"}, Reg_OutputValid, 1'b0);
      @(negedge sys_clock);
      chk({tag, "_vld"}, Reg_OutputValid, 1'b1);
      chk({tag, "_data"}, Reg_OutputData, exp);
      Cart_nCS = 1'b1;
      repeat (3) @(negedge sys_clock);
      chk({tag, "_vld_rel"}, Reg_OutputValid, 1'b0);
      chk({tag, "_data_rel"}, Reg_OutputData, 8'h00);
      Cart_nRD = 1'b1;
   endtask

   logic [9:0] rec_addr [8];
   logic [7:0] rec_data [8];
   logic [9:0] exp_addr [5];
   logic [7:0] exp_data [5];
   logic [7:0] rb_exp;
   logic [47:0] flat_snap;
   int n;
   bit saw_req;

   initial begin
      sys_resetn           = 1'b0;
      Cart_a               = 16'h0000;
      Cart_d               = 8'h00;
      Cart_nRD             = 1'b1;
      Cart_nWR             = 1'b1;
      Cart_nCS             = 1'b1;
      Ram_bank_id          = 5'h10;
      Sig_CamCaptureFinish = 1'b0;
      bif.Bram_WriteRegDone = 1'b0;
      repeat (3) @(negedge sys_clock);
      chk("rst_valid", Reg_OutputValid, 1'b0);
      chk("rst_rdata", Reg_OutputData, 8'h00);
      chk("rst_req", bif.Bram_Req_Write, 1'b0);
      chk("rst_addr", bif.Bram_Addr, 10'h000);
      chk("rst_flat", Reg_Flat, 48'h0);
      chk("rst_ovf", Fifo_Overflow, 1'b0);
      sys_resetn = 1'b1;
      repeat (2) @(negedge sys_clock);

      // capture start then finish
      cpu_write(16'hA000, 8'h03, 5'h10);
      chk("reg0_wr", Reg_Flat[7:0], 8'h03);
      chk("cam_on", Cam_Capture, 1'b1);
      Sig_CamCaptureFinish = 1'b1;
      repeat (4) @(negedge sys_clock);
      Sig_CamCaptureFinish = 1'b0;
      repeat (4) @(negedge sys_clock);
      chk("reg0_fin", Reg_Flat[7:0], 8'h02);
      chk("cam_off", Cam_Capture, 1'b0);

      // write latency: pin edge sampled at k, reg2 updates at k+2
      @(negedge sys_clock);
      Cart_a   = 16'hA002;
      Cart_d   = 8'hC3;
      Cart_nCS = 1'b0;
      repeat (3) @(negedge sys_clock);
      Cart_nWR = 1'b0;
      @(negedge sys_clock);
      chk("lat_k", Reg_Flat[23:16], 8'h00);
      @(negedge sys_clock);
      chk("lat_k1", Reg_Flat[23:16], 8'h00);
      @(negedge sys_clock);
      chk("lat_k2", Reg_Flat[23:16], 8'hC3);
      Cart_nWR = 1'b1;
      repeat (3) @(negedge sys_clock);
      Cart_nCS = 1'b1;
      repeat (3) @(negedge sys_clock);

      // write to reg0 colliding with finish: bit 0 cleared, rest kept
      Cart_a   = 16'hA000;
      Cart_d   = 8'hFF;
      Cart_nCS = 1'b0;
      repeat (3) @(negedge sys_clock);
      Cart_nWR             = 1'b0;
      Sig_CamCaptureFinish = 1'b1;
      repeat (4) @(negedge sys_clock);
      chk("collide_reg0", Reg_Flat[7:0], 8'hFE);
      chk("collide_cam", Cam_Capture, 1'b0);
      Cart_nWR             = 1'b1;
      Sig_CamCaptureFinish = 1'b0;
      repeat (3) @(negedge sys_clock);
      Cart_nCS = 1'b1;
      repeat (3) @(negedge sys_clock);

      // single queued write held until done
      cpu_write(16'hA006, 8'h5A, 5'h10);
      for (int i = 0; i < 5; i++) begin
         chk("hold_req", bif.Bram_Req_Write, 1'b1);
         chk("hold_addr", bif.Bram_Addr, 10'h200);
         chk("hold_data", bif.Bram_Data, 8'h5A);
         @(negedge sys_clock);
      end
      bif.Bram_WriteRegDone = 1'b1;
      @(negedge sys_clock);
      bif.Bram_WriteRegDone = 1'b0;
      chk("done_req", bif.Bram_Req_Write, 1'b0);
      chk("done_addr", bif.Bram_Addr, 10'h000);
      chk("done_data", bif.Bram_Data, 8'h00);
      repeat (3) @(negedge sys_clock);
      chk("done_idle", bif.Bram_Req_Write, 1'b0);

      // busy entry + 4 queued + 1 dropped
      cpu_write(16'hA00B, 8'h15, 5'h10);
      for (int i = 0; i < 5; i++)
         cpu_write(16'hA006 + 16'(i), 8'h10 + 8'(i), 5'h10);
      chk("ovf_set", Fifo_Overflow, 1'b1);
      exp_addr[0] = 10'h205;
      exp_data[0] = 8'h15;
      for (int i = 0; i < 4; i++) begin
         exp_addr[i+1] = 10'h200 + 10'(i);
         exp_data[i+1] = 8'h10 + 8'(i);
      end
      n = 0;
      bif.Bram_WriteRegDone = 1'b1;
      for (int c = 0; c < 24; c++) begin
         if (bif.Bram_Req_Write && n < 8) begin
            rec_addr[n] = bif.Bram_Addr;
            rec_data[n] = bif.Bram_Data;
            n++;
         end
         @(negedge sys_clock);
      end
      bif.Bram_WriteRegDone = 1'b0;
      chk("drain_cnt", 64'(n), 64'd5);
      for (int i = 0; i < 5; i++) begin
         chk("drain_addr", rec_addr[i], exp_addr[i]);
         chk("drain_data", rec_data[i], exp_data[i]);
      end
      chk("ovf_sticky", Fifo_Overflow, 1'b1);

      // window wrap and wrong bank
      cpu_write(16'hA081, 8'h99, 5'h10);
      chk("wrap_reg1", Reg_Flat[15:8], 8'h99);
      flat_snap = Reg_Flat;
      cpu_write(16'hA081, 8'h44, 5'h0F);
      chk("bank_flat", Reg_Flat, flat_snap);
      cpu_write(16'hA006, 8'h44, 5'h0F);
      chk("bank_noreq", bif.Bram_Req_Write, 1'b0);

      // readback
      cpu_write(16'hA001, 8'h77, 5'h10);
`ifdef GBCAM_REG_READBACK_EN
      rb_exp = 8'h77;
`else
      rb_exp = 8'h00;
`endif
      cpu_read("rd_reg1", 16'hA001, rb_exp);
      cpu_read("rd_reg0", 16'hA000, 8'hFE);
      cpu_read("rd_hi", 16'hA010, 8'h00);

      // reset while busy with 3 queued
      for (int i = 0; i < 4; i++)
         cpu_write(16'hA006 + 16'(i), 8'h20 + 8'(i), 5'h10);
      chk("pre_rst_req", bif.Bram_Req_Write, 1'b1);
      sys_resetn = 1'b0;
      #1;
      chk("arst_req", bif.Bram_Req_Write, 1'b0);
      chk("arst_addr", bif.Bram_Addr, 10'h000);
      chk("arst_data", bif.Bram_Data, 8'h00);
      chk("arst_flat", Reg_Flat, 48'h0);
      chk("arst_ovf", Fifo_Overflow, 1'b0);
      chk("arst_cam", Cam_Capture, 1'b0);
      repeat (2) @(negedge sys_clock);
      sys_resetn = 1'b1;
      saw_req = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge sys_clock);
         if (bif.Bram_Req_Write) saw_req = 1'b1;
      end
      chk("post_rst_noreq", saw_req, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
